// File: rtl/mu0_pkg.sv
// Shared types and constants for the MU0 control unit.
// State encoding, opcodes, ALU function selects and the control vector.
package mu0_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned ALUFS_W = 2;

    typedef enum logic [1:0] {
        StFetch = 2'b00,
        StExec  = 2'b01,
        StHalt  = 2'b10
    } state_e;

    localparam logic [OP_W-1:0] OP_LDA = 4'd0;
    localparam logic [OP_W-1:0] OP_STO = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB = 4'd3;
    localparam logic [OP_W-1:0] OP_JMP = 4'd4;
    localparam logic [OP_W-1:0] OP_JGE = 4'd5;
    localparam logic [OP_W-1:0] OP_JNE = 4'd6;
    localparam logic [OP_W-1:0] OP_STP = 4'd7;

    localparam logic [ALUFS_W-1:0] ALUFS_B   = 2'b00;
    localparam logic [ALUFS_W-1:0] ALUFS_INC = 2'b01;
    localparam logic [ALUFS_W-1:0] ALUFS_ADD = 2'b10;
    localparam logic [ALUFS_W-1:0] ALUFS_SUB = 2'b11;

    typedef struct packed {
        logic [ALUFS_W-1:0] alufs;
        logic               asel;
        logic               bsel;
        logic               pc_ce;
        logic               ir_ce;
        logic               acc_ce;
        logic               acc_oe;
        logic               mem_rq;
        logic               mem_rnw;
    } ctrl_t;

    // Safe quiescent vector: no enables, no memory request.
    localparam ctrl_t CTRL_IDLE = '{
        alufs:   ALUFS_B,
        asel:    1'b0,
        bsel:    1'b0,
        pc_ce:   1'b0,
        ir_ce:   1'b0,
        acc_ce:  1'b0,
        acc_oe:  1'b0,
        mem_rq:  1'b0,
        mem_rnw: 1'b1
    };

endpackage

// File: rtl/mu0_control_if.sv
// Control/status bundle between the MU0 control unit and its datapath.
// Perf counter signals exist only when MU0_CTRL_PERF_EN is defined.
interface mu0_control_if;
    import mu0_pkg::*;

    logic [OP_W-1:0]    ir_op;
    logic               acc_zero;
    logic               acc_neg;
    logic               mem_ready;
    logic [ALUFS_W-1:0] alufs;
    logic               asel;
    logic               bsel;
    logic               pc_ce;
    logic               ir_ce;
    logic               acc_ce;
    logic               acc_oe;
    logic               mem_rq;
    logic               mem_rnw;
    logic               halted;
    logic               illegal;
`ifdef MU0_CTRL_PERF_EN
    logic [31:0]        instr_count;
    logic [31:0]        stall_count;
`endif

    modport master (
        input  ir_op, acc_zero, acc_neg, mem_ready,
        output alufs, asel, bsel, pc_ce, ir_ce, acc_ce, acc_oe, mem_rq, mem_rnw,
        output halted, illegal
`ifdef MU0_CTRL_PERF_EN
        , output instr_count, stall_count
`endif
    );

    modport slave (
        output ir_op, acc_zero, acc_neg, mem_ready,
        input  alufs, asel, bsel, pc_ce, ir_ce, acc_ce, acc_oe, mem_rq, mem_rnw,
        input  halted, illegal
`ifdef MU0_CTRL_PERF_EN
        , input instr_count, stall_count
`endif
    );

endinterface

// File: rtl/mu0_decode.sv
// Combinational decode: state, opcode, flags and mem_ready to the control
// vector, next state and the illegal-opcode strobe.
module mu0_decode
    import mu0_pkg::*;
(
    input  state_e          state_i,
    input  logic [OP_W-1:0] ir_op_i,
    input  logic            acc_zero_i,
    input  logic            acc_neg_i,
    input  logic            mem_ready_i,
    output ctrl_t           ctrl_o,
    output state_e          state_o,
    output logic            illegal_o
);

    always_comb begin
        ctrl_o    = CTRL_IDLE;
        state_o   = state_i;
        illegal_o = 1'b0;
        case (state_i)
            StFetch: begin
                ctrl_o.asel    = 1'b0;
                ctrl_o.bsel    = 1'b1;
                ctrl_o.alufs   = ALUFS_INC;
                ctrl_o.mem_rq  = 1'b1;
                ctrl_o.mem_rnw = 1'b1;
                ctrl_o.ir_ce   = mem_ready_i;
                ctrl_o.pc_ce   = mem_ready_i;
                state_o        = mem_ready_i ? StExec : StFetch;
            end
            StExec: begin
                ctrl_o.asel = 1'b1;
                case (ir_op_i)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ctrl_o.bsel    = 1'b0;
                        ctrl_o.alufs   = (ir_op_i == OP_ADD) ? ALUFS_ADD :
                                         (ir_op_i == OP_SUB) ? ALUFS_SUB : ALUFS_B;
                        ctrl_o.mem_rq  = 1'b1;
                        ctrl_o.mem_rnw = 1'b1;
                        ctrl_o.acc_ce  = mem_ready_i;
                    end
                    OP_STO: begin
                        ctrl_o.mem_rq  = 1'b1;
                        ctrl_o.mem_rnw = 1'b0;
                        ctrl_o.acc_oe  = 1'b1;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        ctrl_o.bsel  = 1'b1;
                        ctrl_o.alufs = ALUFS_B;
                        ctrl_o.pc_ce = (ir_op_i == OP_JGE) ? !acc_neg_i  :
                                       (ir_op_i == OP_JNE) ? !acc_zero_i : 1'b1;
                        state_o      = StFetch;
                    end
                    OP_STP: state_o = StHalt;
                    default: begin
                        illegal_o = 1'b1;
                        state_o   = StHalt;
                    end
                endcase
                // Memory ops retire only when the access completes.
                if (ctrl_o.mem_rq) begin
                    state_o = mem_ready_i ? StFetch : StExec;
                end
            end
            StHalt:  state_o = StHalt;
            default: state_o = StFetch;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit top: state register, sticky illegal flag and, with
// MU0_CTRL_PERF_EN defined, saturating instruction/stall counters.
module mu0_control
    import mu0_pkg::*;
(
    input logic           clk,
    input logic           reset,
    mu0_control_if.master bus
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   set_illegal;
    ctrl_t  dec_ctrl, ctrl;

    mu0_decode u_decode (
        .state_i     (state_q),
        .ir_op_i     (bus.ir_op),
        .acc_zero_i  (bus.acc_zero),
        .acc_neg_i   (bus.acc_neg),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (dec_ctrl),
        .state_o     (state_d),
        .illegal_o   (set_illegal)
    );

    // Outputs are combinational, so reset must mask them directly.
    always_comb begin
        ctrl      = reset ? dec_ctrl : CTRL_IDLE;
        illegal_d = illegal_q | set_illegal;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.alufs   = ctrl.alufs;
    assign bus.asel    = ctrl.asel;
    assign bus.bsel    = ctrl.bsel;
    assign bus.pc_ce   = ctrl.pc_ce;
    assign bus.ir_ce   = ctrl.ir_ce;
    assign bus.acc_ce  = ctrl.acc_ce;
    assign bus.acc_oe  = ctrl.acc_oe;
    assign bus.mem_rq  = ctrl.mem_rq;
    assign bus.mem_rnw = ctrl.mem_rnw;
    assign bus.halted  = reset && (state_q == StHalt);
    assign bus.illegal = illegal_q;

`ifdef MU0_CTRL_PERF_EN
    logic [31:0] instr_count_q, instr_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        instr_count_d = instr_count_q;
        stall_count_d = stall_count_q;
        if (state_q == StExec && state_d != StExec && instr_count_q != 32'hFFFF_FFFF) begin
            instr_count_d = instr_count_q + 32'd1;
        end
        if (ctrl.mem_rq && !bus.mem_ready && stall_count_q != 32'hFFFF_FFFF) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.instr_count = instr_count_q;
    assign bus.stall_count = stall_count_q;
`endif

endmodule
